// File: rtl/vga_pong_engine.sv
// vga_pong_engine: VGA beam timing, registered pixel rendering and a
// frame-synchronous pong game (paddles, ball physics, serve/score FSM).
module vga_pong_engine #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FPORCH      = 16,
    parameter int H_PULSE       = 96,
    parameter int H_BPORCH      = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FPORCH      = 10,
    parameter int V_PULSE       = 2,
    parameter int V_BPORCH      = 33,
    parameter int SYNC_POL      = 0,
    parameter int COLOR_BITS    = 3,
    parameter int PADDLE_HALF_H = 30,
    parameter int PADDLE_W      = 10,
    parameter int PADDLE_STEP   = 2,
    parameter int BALL_HALF     = 3,
    parameter int MAX_SPEED     = 6,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Serve,
    input  logic                  i_L_Up,
    input  logic                  i_L_Dn,
    input  logic                  i_R_Up,
    input  logic                  i_R_Dn,
    output logic                  o_VGA_HSync,
    output logic                  o_VGA_VSync,
    output logic [COLOR_BITS-1:0] o_VGA_Red,
    output logic [COLOR_BITS-1:0] o_VGA_Grn,
    output logic [COLOR_BITS-1:0] o_VGA_Blu,
    output logic [3:0]            o_Score_L,
    output logic [3:0]            o_Score_R,
    output logic                  o_Game_Over
);
    localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_PULSE + H_BPORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_PULSE + V_BPORCH;
    localparam int CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
    localparam int FW      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_HLAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_VLAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_VTICK = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] C_HA    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_VA    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_HS0   = CW'(H_ACTIVE + H_FPORCH);
    localparam logic [CW-1:0] C_HS1   = CW'(H_ACTIVE + H_FPORCH + H_PULSE);
    localparam logic [CW-1:0] C_VS0   = CW'(V_ACTIVE + V_FPORCH);
    localparam logic [CW-1:0] C_VS1   = CW'(V_ACTIVE + V_FPORCH + V_PULSE);
    localparam logic [CW-1:0] C_PHH   = CW'(PADDLE_HALF_H);
    localparam logic [CW-1:0] C_PW    = CW'(PADDLE_W);
    localparam logic [CW-1:0] C_RPAD  = CW'(H_ACTIVE - PADDLE_W);
    localparam logic [CW-1:0] C_STEP  = CW'(PADDLE_STEP);
    localparam logic [CW-1:0] C_PMAX  = CW'(V_ACTIVE - 1 - PADDLE_HALF_H);
    localparam logic [CW-1:0] C_BH    = CW'(BALL_HALF);
    localparam logic [CW-1:0] C_XC    = CW'(H_ACTIVE / 2);
    localparam logic [CW-1:0] C_YC    = CW'(V_ACTIVE / 2);
    localparam logic [CW-1:0] C_NET0  = CW'(H_ACTIVE / 2 - 1);
    localparam logic [CW-1:0] C_XL    = CW'(PADDLE_W + BALL_HALF);
    localparam logic [CW-1:0] C_XR    = CW'(H_ACTIVE - 1 - PADDLE_W - BALL_HALF);
    localparam logic [CW-1:0] C_YBOT  = CW'(V_ACTIVE - 1 - BALL_HALF);
    localparam logic [CW-1:0] C_HIT   = CW'(PADDLE_HALF_H + BALL_HALF);
    localparam logic [CW-1:0] C_MAXSP = CW'(MAX_SPEED);
    localparam logic [FW-1:0] C_SLAST = FW'(SERVE_FRAMES - 1);
    localparam logic [3:0]    C_WIN   = 4'(WIN_SCORE);
    localparam logic          SP      = (SYNC_POL != 0);

    typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

    state_t                  state_q;
    logic [CW-1:0]           col_q, row_q, col_d, row_d;
    logic [CW-1:0]           pad_l_q, pad_r_q, pad_l_d, pad_r_d;
    logic [CW-1:0]           x_q, y_q, speed_q, speed_up;
    logic                    dx_q, dy_q;          // 1 = right / down
    logic [FW-1:0]           cnt_q;
    logic [3:0]              sl_q, sr_q;
    logic                    go_q, tick, hit_l, hit_r;
    logic                    hs_q, vs_q, hs_d, vs_d;
    logic [COLOR_BITS-1:0]   red_q, grn_q, blu_q, red_d, grn_d, blu_d;

    function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        absdiff = (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [CW-1:0] pad_next(input logic [CW-1:0] p, input logic up, input logic dn);
        pad_next = p;
        if (up && !dn)
            pad_next = (p < C_PHH + C_STEP) ? C_PHH : p - C_STEP;
        else if (dn && !up)
            pad_next = (p + C_STEP > C_PMAX) ? C_PMAX : p + C_STEP;
    endfunction

    assign tick     = (col_q == C_HLAST) && (row_q == C_VTICK);
    assign pad_l_d  = pad_next(pad_l_q, i_L_Up, i_L_Dn);
    assign pad_r_d  = pad_next(pad_r_q, i_R_Up, i_R_Dn);
    assign speed_up = (speed_q >= C_MAXSP) ? C_MAXSP : speed_q + C_ONE;
    assign hit_l    = absdiff(y_q, pad_l_q) <= C_HIT;
    assign hit_r    = absdiff(y_q, pad_r_q) <= C_HIT;

    // Beam counter next-state: column wraps, row advances on column wrap
    always_comb begin
        col_d = col_q + C_ONE;
        row_d = row_q;
        if (col_q == C_HLAST) begin
            col_d = '0;
            row_d = (row_q == C_VLAST) ? '0 : row_q + C_ONE;
        end
    end

    // Beam counters
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Pixel colour and sync for the current beam position
    always_comb begin
        hs_d  = ((col_q >= C_HS0) && (col_q < C_HS1)) ? SP : ~SP;
        vs_d  = ((row_q >= C_VS0) && (row_q < C_VS1)) ? SP : ~SP;
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if ((col_q < C_HA) && (row_q < C_VA)) begin
            if ((col_q < C_PW) && (absdiff(row_q, pad_l_q) <= C_PHH)) begin
                red_d = '1;
                grn_d = '1;
            end else if ((col_q >= C_RPAD) && (absdiff(row_q, pad_r_q) <= C_PHH)) begin
                grn_d = '1;
                blu_d = '1;
            end else if ((state_q == S_SERVE || state_q == S_PLAY) &&
                         (absdiff(col_q, x_q) <= C_BH) && (absdiff(row_q, y_q) <= C_BH)) begin
                grn_d = '1;
            end else if ((col_q == C_NET0 || col_q == C_XC) && !row_q[4]) begin
                red_d = '1;
                grn_d = '1;
                blu_d = '1;
            end
        end
    end

    // Registered video outputs, one clock behind the counters
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hs_q  <= ~SP;
            vs_q  <= ~SP;
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            red_q <= red_d;
            grn_q <= grn_d;
            blu_q <= blu_d;
        end
    end

    // Paddle positions, updated once per frame
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pad_l_q <= C_YC;
            pad_r_q <= C_YC;
        end else if (tick) begin
            pad_l_q <= pad_l_d;
            pad_r_q <= pad_r_d;
        end
    end

    // Serve/play/score state machine and ball physics, once per frame
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            x_q     <= C_XC;
            y_q     <= C_YC;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            speed_q <= C_ONE;
            cnt_q   <= '0;
            sl_q    <= '0;
            sr_q    <= '0;
            go_q    <= 1'b0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    x_q <= C_XC;
                    y_q <= C_YC;
                    if (i_Serve) begin
                        state_q <= S_SERVE;
                        cnt_q   <= '0;
                    end
                end
                S_SERVE: begin
                    x_q <= C_XC;
                    y_q <= C_YC;
                    if (cnt_q == C_SLAST) begin
                        state_q <= S_PLAY;
                        speed_q <= C_ONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    // Vertical and horizontal events are independent; the
                    // paddle hit test uses the pre-move y.
                    if (dy_q && (y_q >= C_YBOT)) begin
                        dy_q <= 1'b0;
                        y_q  <= y_q - C_ONE;
                    end else if (!dy_q && (y_q <= C_BH)) begin
                        dy_q <= 1'b1;
                        y_q  <= y_q + C_ONE;
                    end else begin
                        y_q <= dy_q ? y_q + C_ONE : y_q - C_ONE;
                    end
                    if (!dx_q && (x_q <= C_XL + speed_q)) begin
                        if (hit_l) begin
                            x_q     <= C_XL;
                            dx_q    <= 1'b1;
                            speed_q <= speed_up;
                        end else begin
                            if (sr_q < C_WIN) sr_q <= sr_q + 4'd1;
                            dx_q    <= 1'b0;
                            state_q <= S_POINT;
                        end
                    end else if (dx_q && (x_q + speed_q >= C_XR)) begin
                        if (hit_r) begin
                            x_q     <= C_XR;
                            dx_q    <= 1'b0;
                            speed_q <= speed_up;
                        end else begin
                            if (sl_q < C_WIN) sl_q <= sl_q + 4'd1;
                            dx_q    <= 1'b1;
                            state_q <= S_POINT;
                        end
                    end else begin
                        x_q <= dx_q ? x_q + speed_q : x_q - speed_q;
                    end
                end
                S_POINT: begin
                    x_q   <= C_XC;
                    y_q   <= C_YC;
                    cnt_q <= '0;
                    if (sl_q == C_WIN || sr_q == C_WIN) begin
                        state_q <= S_OVER;
                        go_q    <= 1'b1;
                    end else begin
                        state_q <= S_SERVE;
                    end
                end
                S_OVER: begin
                    x_q <= C_XC;
                    y_q <= C_YC;
                    if (i_Serve) begin
                        sl_q    <= '0;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        go_q    <= 1'b0;
                        state_q <= S_SERVE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_VGA_HSync = hs_q;
    assign o_VGA_VSync = vs_q;
    assign o_VGA_Red   = red_q;
    assign o_VGA_Grn   = grn_q;
    assign o_VGA_Blu   = blu_q;
    assign o_Score_L   = sl_q;
    assign o_Score_R   = sr_q;
    assign o_Game_Over = go_q;

endmodule

// File: tb/tb_vga_pong_engine.sv
// tb_vga_pong_engine: small-geometry pong core checked every clock against a
// frame-level behavioural model of the game and a per-pixel render model.
module tb_vga_pong_engine;
    localparam int HA = 24, HF = 2, HP = 3, HB = 1;
    localparam int VA = 20, VF = 1, VP = 2, VB = 1;
    localparam int SPOL = 0, CB = 3;
    localparam int PHH = 3, PW = 2, STEP = 1, BH = 1, MAXS = 3, SF = 3, WIN = 2;
    localparam int HT = HA + HF + HP + HB;
    localparam int VT = VA + VF + VP + VB;
    localparam int FRAME = HT * VT;

    localparam int G_IDLE = 0, G_SERVE = 1, G_PLAY = 2, G_POINT = 3, G_OVER = 4;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          serve = 1'b0, lu = 1'b0, ld = 1'b0, ru = 1'b0, rd = 1'b0;
    logic          hs, vs, go;
    logic [CB-1:0] red, grn, blu;
    logic [3:0]    sl, sr;

    vga_pong_engine #(
        .H_ACTIVE(HA), .H_FPORCH(HF), .H_PULSE(HP), .H_BPORCH(HB),
        .V_ACTIVE(VA), .V_FPORCH(VF), .V_PULSE(VP), .V_BPORCH(VB),
        .SYNC_POL(SPOL), .COLOR_BITS(CB),
        .PADDLE_HALF_H(PHH), .PADDLE_W(PW), .PADDLE_STEP(STEP),
        .BALL_HALF(BH), .MAX_SPEED(MAXS), .SERVE_FRAMES(SF), .WIN_SCORE(WIN)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Serve(serve),
        .i_L_Up(lu), .i_L_Dn(ld), .i_R_Up(ru), .i_R_Dn(rd),
        .o_VGA_HSync(hs), .o_VGA_VSync(vs),
        .o_VGA_Red(red), .o_VGA_Grn(grn), .o_VGA_Blu(blu),
        .o_Score_L(sl), .o_Score_R(sr), .o_Game_Over(go)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mst, mcnt, mpl, mpr, mbx, mby, mdx, mdy, mspd, msl, msr, mcol, mrow;
    logic       e_hs, e_vs;
    logic [8:0] e_rgb;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        mst = G_IDLE; mcnt = 0; mpl = VA / 2; mpr = VA / 2;
        mbx = HA / 2; mby = VA / 2; mdx = 1; mdy = 1; mspd = 1;
        msl = 0; msr = 0; mcol = 0; mrow = 0;
        e_hs = (SPOL == 0); e_vs = (SPOL == 0); e_rgb = '0;
    endtask

    task automatic render(input int c, input int r);
        logic act_h, act_v;
        act_h = (c >= HA + HF) && (c < HA + HF + HP);
        act_v = (r >= VA + VF) && (r < VA + VF + VP);
        e_hs  = act_h ? (SPOL != 0) : (SPOL == 0);
        e_vs  = act_v ? (SPOL != 0) : (SPOL == 0);
        e_rgb = 9'o000;
        if (c < HA && r < VA) begin
            if (c < PW && iabs(r - mpl) <= PHH)                  e_rgb = 9'o770;
            else if (c >= HA - PW && iabs(r - mpr) <= PHH)       e_rgb = 9'o077;
            else if ((mst == G_SERVE || mst == G_PLAY) &&
                     iabs(c - mbx) <= BH && iabs(r - mby) <= BH) e_rgb = 9'o070;
            else if ((c == HA / 2 - 1 || c == HA / 2) && ((r / 16) % 2 == 0))
                                                                 e_rgb = 9'o777;
        end
    endtask

    // One game frame, using the button levels present at the tick
    task automatic model_frame();
        int oy;
        case (mst)
            G_IDLE:  if (serve) begin mst = G_SERVE; mcnt = 0; end
            G_SERVE: begin
                if (mcnt == SF - 1) begin mst = G_PLAY; mspd = 1; end
                else mcnt++;
            end
            G_PLAY: begin
                oy = mby;
                if (mdy > 0 && mby >= VA - 1 - BH)  begin mdy = -1; mby -= 1; end
                else if (mdy < 0 && mby <= BH)      begin mdy = 1;  mby += 1; end
                else mby += mdy;
                if (mdx < 0 && mbx <= PW + BH + mspd) begin
                    if (iabs(oy - mpl) <= PHH + BH) begin
                        mbx = PW + BH; mdx = 1; mspd = (mspd + 1 > MAXS) ? MAXS : mspd + 1;
                    end else begin
                        msr = (msr + 1 > WIN) ? WIN : msr + 1; mdx = -1; mst = G_POINT;
                    end
                end else if (mdx > 0 && mbx >= HA - 1 - PW - BH - mspd) begin
                    if (iabs(oy - mpr) <= PHH + BH) begin
                        mbx = HA - 1 - PW - BH; mdx = -1; mspd = (mspd + 1 > MAXS) ? MAXS : mspd + 1;
                    end else begin
                        msl = (msl + 1 > WIN) ? WIN : msl + 1; mdx = 1; mst = G_POINT;
                    end
                end else begin
                    mbx += mdx * mspd;
                end
            end
            G_POINT: begin
                mst = (msl == WIN || msr == WIN) ? G_OVER : G_SERVE;
                mcnt = 0;
            end
            default: if (serve) begin msl = 0; msr = 0; mcnt = 0; mst = G_SERVE; end
        endcase
        if (mst != G_PLAY) begin mbx = HA / 2; mby = VA / 2; end
        mpl = clampi(mpl + STEP * (int'(ld) - int'(lu)), PHH, VA - 1 - PHH);
        mpr = clampi(mpr + STEP * (int'(rd) - int'(ru)), PHH, VA - 1 - PHH);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (col %0d row %0d)", tag, obs, exp, mcol, mrow);
        end
    endtask

    task automatic check_all();
        check("hsync", 32'(hs), 32'(e_hs));
        check("vsync", 32'(vs), 32'(e_vs));
        check("rgb", 32'({red, grn, blu}), 32'(e_rgb));
        check("score_l", 32'(sl), 32'(msl));
        check("score_r", 32'(sr), 32'(msr));
        check("game_over", 32'(go), 32'(mst == G_OVER));
    endtask

    // Advance one clock: model the edge, then compare just after it
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            render(mcol, mrow);
            if (mcol == HT - 1 && mrow == VA - 1) model_frame();
            if (mcol == HT - 1) begin
                mcol = 0;
                mrow = (mrow == VT - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        check_all();
    endtask

    task automatic random_inputs();
        if ($urandom_range(0, 1) == 1) begin lu = (mby < mpl); ld = (mby > mpl); end
        else begin lu = 1'($urandom); ld = 1'($urandom); end
        if ($urandom_range(0, 3) != 0) begin ru = (mby < mpr); rd = (mby > mpr); end
        else begin ru = 1'($urandom); rd = 1'($urandom); end
        serve = ($urandom_range(0, 3) == 0);
    endtask

    task automatic run_frames(input int n, input bit rnd);
        for (int i = 0; i < n * FRAME; i++) begin
            step();
            if (rnd && mcol == 0 && mrow == 0) random_inputs();
        end
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1 check_all();
        rst_n = 1'b1;

        // Paddle clamps: left up to the top, right down to the bottom
        lu = 1'b1; rd = 1'b1;
        run_frames(10, 1'b0);
        // Both buttons: no move
        ld = 1'b1; ru = 1'b1;
        run_frames(2, 1'b0);
        lu = 1'b0; ld = 1'b0; ru = 1'b0; rd = 1'b0;

        // First serve from IDLE, deterministic travel toward the right
        serve = 1'b1;
        run_frames(1, 1'b0);
        serve = 1'b0;
        run_frames(13, 1'b0);

        // Randomized play
        run_frames(70, 1'b1);

        // Reset mid-frame and mid-game: outputs return immediately
        repeat (300) step();
        rst_n = 1'b0;
        #1 check_all();
        repeat (2) step();
        rst_n = 1'b1;
        serve = 1'b1;
        run_frames(20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pong_engine.md
Name: vga_pong_engine

Overview:
- Parametrised next-generation VGA Pong core: sync/beam timing, per-pixel colour, ball/paddle physics, serve/score state machine.
- Generalised in timing, colour depth, object geometry and speed.
- Adds over the previous generation: frame-synchronous game updates, speed-up on return, score limit with game-over, serve countdown, centre net, sync polarity, registered pixel outputs.
- Sits between board buttons and the VGA resistor DAC; scores go to an external 7-segment driver.

Parameters:
H_ACTIVE, 640, visible columns
H_FPORCH, 16, horizontal front porch (clocks)
H_PULSE, 96, hsync width
H_BPORCH, 48, horizontal back porch
V_ACTIVE, 480, visible rows
V_FPORCH, 10, vertical front porch (lines)
V_PULSE, 2, vsync width
V_BPORCH, 33, vertical back porch
SYNC_POL, 0, active sync level (0 = active-low)
COLOR_BITS, 3, bits per colour channel
PADDLE_HALF_H, 30, paddle half-height (rows)
PADDLE_W, 10, paddle width (columns)
PADDLE_STEP, 2, paddle rows moved per frame
BALL_HALF, 3, ball half-size
MAX_SPEED, 6, max horizontal ball speed (pixels/frame)
SERVE_FRAMES, 60, frames of serve pause
WIN_SCORE, 9, points to win (1..15)

Ports:
i_Clk  in  1  pixel clock
i_Rst_n  in  1  asynchronous active-low reset
i_Serve  in  1  start/serve request (level)
i_L_Up  in  1  left paddle up
i_L_Dn  in  1  left paddle down
i_R_Up  in  1  right paddle up
i_R_Dn  in  1  right paddle down
o_VGA_HSync  out  1  horizontal sync
o_VGA_VSync  out  1  vertical sync
o_VGA_Red  out  COLOR_BITS  red DAC
o_VGA_Grn  out  COLOR_BITS  green DAC
o_VGA_Blu  out  COLOR_BITS  blue DAC
o_Score_L  out  4  left score
o_Score_R  out  4  right score
o_Game_Over  out  1  high in GAME_OVER state

Behaviour:
- Reset (async assert, sync release):
  - column/row = 0; syncs at inactive level (~SYNC_POL); colour outputs 0.
  - Scores 0; state IDLE; paddles at V_ACTIVE/2; ball at (H_ACTIVE/2, V_ACTIVE/2).
  - Speed 1; dx right; dy down; o_Game_Over 0.
- Timing:
  - H_TOTAL = sum of H params; V_TOTAL likewise.
  - column wraps at H_TOTAL-1; row increments on column wrap and wraps at V_TOTAL-1.
  - Counter width = $clog2 of the larger total.
  - hsync active for column in [H_ACTIVE+H_FPORCH, H_ACTIVE+H_FPORCH+H_PULSE); vsync uses the same rule with row.
- Registered outputs: syncs and colours are registered from the current counters, so all outputs lag the counters by exactly 1 clock and stay mutually aligned.
- Pixel colour:
  - Zero outside the active area.
  - Priority: paddles > ball > net > black.
  - Left paddle: column < PADDLE_W and |row-padL| <= PADDLE_HALF_H; colour = yellow (R,G all-ones).
  - Right paddle: column >= H_ACTIVE-PADDLE_W; colour = cyan (G,B all-ones).
  - Ball: |col-x| <= BALL_HALF and |row-y| <= BALL_HALF; colour = green. Hidden in IDLE, POINT and GAME_OVER.
  - Net: column in {H_ACTIVE/2-1, H_ACTIVE/2} and row[4]==0; colour = white.
- Frame tick:
  - One-clock pulse at column==H_TOTAL-1, row==V_ACTIVE-1.
  - All game state changes only on the tick, so there is no tearing.
- Paddles:
  - On tick, up moves -PADDLE_STEP and down moves +PADDLE_STEP.
  - Both or neither pressed: no move.
  - Position clamped to [PADDLE_HALF_H, V_ACTIVE-1-PADDLE_HALF_H].
  - Active in every state.
- FSM (evaluated on tick):
  - IDLE: ball centred; i_Serve -> SERVE.
  - SERVE: ball centred; frame counter counts SERVE_FRAMES, then PLAY with speed 1.
    - dx points toward the player who lost the last point; the first serve goes right.
    - dy keeps its last value.
  - PLAY, vertical: if dy down and y >= V_ACTIVE-1-BALL_HALF, flip dy and set y-1. If dy up and y <= BALL_HALF, flip dy and set y+1. Otherwise y += dy.
  - PLAY, left edge: if dx left and x <= PADDLE_W+BALL_HALF+speed:
    - Hit when |y-padL| <= PADDLE_HALF_H+BALL_HALF: x = PADDLE_W+BALL_HALF, dx right, speed = min(speed+1, MAX_SPEED).
    - Miss: R score +1, go to POINT.
  - PLAY, right edge: mirrored, with x = H_ACTIVE-1-PADDLE_W-BALL_HALF.
  - PLAY, otherwise: x += speed in the dx direction.
  - Wall and paddle events in the same tick are both applied.
  - POINT (one frame): scorer's score == WIN_SCORE -> GAME_OVER, else SERVE.
  - GAME_OVER: scores frozen; i_Serve -> clear scores, then SERVE.
- Scores never exceed WIN_SCORE.
- Reset mid-frame or mid-game returns immediately to reset values.

Test Plan:
- Defaults; release reset at t0 -> o_VGA_HSync low on clocks 657..752; period 800; vsync low on rows 490..491; frame = 420000 clocks.
- Defaults; pixel (320,200) -> net white (7,7,7) one clock after column==320, row==200; column 640 -> all colour 0.
- i_L_Up held 300 frames from centre -> padL decrements 2/frame, stops at 30; i_L_Up+i_L_Dn together -> no change.
- i_Serve in IDLE -> ball hidden until SERVE, centred 60 frames, then moves right 1 px/frame; right paddle aligned -> bounce, x=626, speed 2.
- Right paddle parked at 30, ball arrives at y=240 -> o_Score_L=1, POINT for 1 frame, next serve travels right.
- WIN_SCORE=2; left wins two points -> o_Game_Over=1, scores frozen 2/0; i_Serve -> scores 0, SERVE; assert i_Rst_n low mid-PLAY -> all outputs to reset values immediately.
